// File: rtl/otter_if_pkg.sv
// Shared types and constants for the OTTER instruction-fetch front end.
package otter_if_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  localparam logic [31:0] OTTER_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_if_fifo.sv
// Circular queue of fetched {pc, instr} entries; clear dominates push and pop.
module otter_if_fifo
  import otter_if_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int CNT_W = $clog2(QDEPTH + 1),
  localparam int PTR_W = $clog2(QDEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  if_entry_t        entry_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output if_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  if_entry_t        mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push_i & ~clear_i;
  assign do_pop  = pop_i & ~clear_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the head is masked to zero while
  // empty, so stale words are never visible and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(QDEPTH));
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/otter_if_stage.sv
// OTTER fetch stage: owns the PC, issues reads to the 1-cycle instruction
// memory and hands buffered instructions to decode over valid/ready.
module otter_if_stage
  import otter_if_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = OTTER_RESET_VEC,
  parameter int          QDEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        IMEM_RDEN,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DOUT,
  output logic        IF_VALID,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  input  logic        ID_READY,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count;
  logic             full, empty;
  logic             pop, push, issue;
  logic [31:0]      occupancy;
  if_entry_t        head;

  assign pop  = IF_VALID & ID_READY & ~BR_TAKEN;
  assign push = inflight_q & ~BR_TAKEN;

  // Every outstanding request holds a reserved slot, so the queue cannot overflow.
  assign occupancy = 32'(count) + 32'(inflight_q) - 32'(pop);
  assign issue     = RESET_N & ~BR_TAKEN & (occupancy < 32'(QDEPTH));

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (BR_TAKEN) begin
      pc_d = word_align(BR_TARGET);
    end else if (issue) begin
      pc_d       = pc_q + 32'd4;
      tag_d      = pc_q;
      inflight_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q       <= RESET_VEC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  otter_if_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .push_i  (push),
    .entry_i ('{pc: tag_q, instr: IMEM_DOUT}),
    .pop_i   (pop),
    .clear_i (BR_TAKEN),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign IMEM_RDEN = issue;
  assign IMEM_ADDR = pc_q;
  assign IF_VALID  = ~empty;
  assign IF_PC     = head.pc;
  assign IF_INSTR  = head.instr;

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET_N)
    !(push && full && !pop));

endmodule
